// File: rtl/pulse_timer_pkg.sv
// pulse_timer_pkg: state encoding and default counter width shared by the pulse timer files
package pulse_timer_pkg;
  localparam int CNT_W_DEF = 8;
  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    PULSE = 2'b01,
    GAP   = 2'b10
  } state_t;
endpackage

// File: rtl/pt_down_counter.sv
// pt_down_counter: loadable down-counter that saturates at zero, with a zero flag decoded from the register
module pt_down_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset_b,
  input  logic             load,
  input  logic             dec,
  input  logic [CNT_W-1:0] load_val,
  output logic [CNT_W-1:0] count,
  output logic             zero
);
  // load wins over decrement; decrement stops at zero so the count never wraps
  always_ff @(posedge clk or negedge reset_b)
    if (!reset_b) count <= '0;
    else if (load) count <= load_val;
    else if (dec && count != '0) count <= count - 1'b1;
  assign zero = (count == '0);
endmodule

// File: rtl/pulse_timer.sv
// pulse_timer: programmable one-shot/periodic pulse generator; define PULSE_TIMER_RETRIG_EN to let start retrigger while busy
module pulse_timer
  import pulse_timer_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset_b,
  input  logic             start,
  input  logic [CNT_W-1:0] len,
  input  logic [CNT_W-1:0] gap,
  input  logic             periodic,
  input  logic             stop,
  output logic             out,
  output logic             busy,
  output logic             done
);
`ifdef PULSE_TIMER_RETRIG_EN
  localparam bit RETRIG = 1'b1;
`else
  localparam bit RETRIG = 1'b0;
`endif
  state_t           state, nxt;
  logic [CNT_W-1:0] len_q, gap_q, ld_val, count;
  logic             per_q, ld, dc, zero, accept;
  assign accept = start && len != '0 && !stop && (state == IDLE || RETRIG);
  pt_down_counter #(.CNT_W(CNT_W)) u_cnt (
    .clk      (clk),
    .reset_b  (reset_b),
    .load     (ld),
    .dec      (dc),
    .load_val (ld_val),
    .count    (count),
    .zero     (zero)
  );
  // next state and counter control; stop beats start, start beats expiry
  always_comb begin
    nxt    = state;
    ld     = 1'b0;
    dc     = 1'b0;
    ld_val = '0;
    if (state != IDLE && stop) begin
      nxt = IDLE;
      ld  = 1'b1;
    end else if (accept) begin
      nxt    = PULSE;
      ld     = 1'b1;
      ld_val = len - 1'b1;
    end else if (state == PULSE) begin
      if (!zero) dc = 1'b1;
      else if (!per_q) nxt = IDLE;
      else if (gap_q != '0) begin
        nxt    = GAP;
        ld     = 1'b1;
        ld_val = gap_q - 1'b1;
      end else begin
        ld     = 1'b1;
        ld_val = len_q - 1'b1;
      end
    end else if (state == GAP) begin
      if (!zero) dc = 1'b1;
      else begin
        nxt    = PULSE;
        ld     = 1'b1;
        ld_val = len_q - 1'b1;
      end
    end
  end
  // state register and operand latches, captured only when a start is accepted
  always_ff @(posedge clk or negedge reset_b)
    if (!reset_b) begin
      state <= IDLE;
      len_q <= '0;
      gap_q <= '0;
      per_q <= 1'b0;
    end else begin
      state <= nxt;
      if (accept) begin
        len_q <= len;
        gap_q <= gap;
        per_q <= periodic;
      end
    end
  assign out  = (state == PULSE);
  assign busy = (state != IDLE);
  assign done = (state == PULSE) && zero;
endmodule

// File: tb/tb_pulse_timer.sv
// tb_pulse_timer: directed self-checking bench for pulse_timer
module tb_pulse_timer;
  logic       clk = 1'b0;
  logic       reset_b = 1'b0;
  logic       start = 1'b0;
  logic [7:0] len = '0;
  logic [7:0] gap = '0;
  logic       periodic = 1'b0;
  logic       stop = 1'b0;
  logic       out, busy, done;
  int checks = 0;
  int errors = 0;
  logic [511:0] ov, dv, bv;

  pulse_timer dut (
    .clk      (clk),
    .reset_b  (reset_b),
    .start    (start),
    .len      (len),
    .gap      (gap),
    .periodic (periodic),
    .stop     (stop),
    .out      (out),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic fire(input logic [7:0] l, input logic [7:0] g, input logic p);
    start = 1'b1; len = l; gap = g; periodic = p;
    step();
    start = 1'b0;
  endtask

  task automatic observe(input int n);
    ov = '0; dv = '0; bv = '0;
    for (int i = 0; i < n; i++) begin
      ov[i] = out; dv[i] = done; bv[i] = busy;
      step();
    end
  endtask

  task automatic do_stop();
    stop = 1'b1;
    step();
    stop = 1'b0;
  endtask

  task automatic test_reset();
    reset_b = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks += 3;
    if (out !== 1'b0) begin errors++; $display("FAIL reset_out got %b exp 0", out); end
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", done); end
    reset_b = 1'b1;
    step();
  endtask

  task automatic test_one_shot();
    fire(8'd8, 8'd0, 1'b0);
    observe(12);
    checks += 3;
    if (ov[11:0] !== 12'h0FF) begin errors++; $display("FAIL oneshot_out got %h exp 0ff", ov[11:0]); end
    if (dv[11:0] !== 12'h080) begin errors++; $display("FAIL oneshot_done got %h exp 080", dv[11:0]); end
    if (bv[11:0] !== 12'h0FF) begin errors++; $display("FAIL oneshot_busy got %h exp 0ff", bv[11:0]); end
  endtask

  task automatic test_zero_len();
    fire(8'd0, 8'd0, 1'b0);
    observe(4);
    checks += 2;
    if (ov[3:0] !== 4'h0) begin errors++; $display("FAIL zerolen_out got %h exp 0", ov[3:0]); end
    if (bv[3:0] !== 4'h0) begin errors++; $display("FAIL zerolen_busy got %h exp 0", bv[3:0]); end
  endtask

  task automatic test_max_len();
    fire(8'd255, 8'd0, 1'b0);
    observe(260);
    checks += 3;
    if (ov[259:0] !== {5'b0, {255{1'b1}}}) begin errors++; $display("FAIL maxlen_out highs %0d exp 255", $countones(ov)); end
    if (dv[259:0] !== (260'd1 << 254)) begin errors++; $display("FAIL maxlen_done count %0d exp 1 at 254", $countones(dv)); end
    if (bv[259:0] !== {5'b0, {255{1'b1}}}) begin errors++; $display("FAIL maxlen_busy highs %0d exp 255", $countones(bv)); end
  endtask

  task automatic test_periodic();
    fire(8'd3, 8'd2, 1'b1);
    observe(15);
    checks += 3;
    if (ov[14:0] !== 15'b00111_00111_00111) begin errors++; $display("FAIL per_out got %b exp 001110011100111", ov[14:0]); end
    if (dv[14:0] !== 15'b00100_00100_00100) begin errors++; $display("FAIL per_done got %b exp 001000010000100", dv[14:0]); end
    if (bv[14:0] !== 15'h7FFF) begin errors++; $display("FAIL per_busy got %b exp all ones", bv[14:0]); end
    do_stop();
    checks += 1;
    if (busy !== 1'b0 || out !== 1'b0) begin errors++; $display("FAIL per_stop busy %b out %b exp 0 0", busy, out); end
    fire(8'd3, 8'd0, 1'b1);
    observe(9);
    checks += 2;
    if (ov[8:0] !== 9'h1FF) begin errors++; $display("FAIL gap0_out got %b exp 111111111", ov[8:0]); end
    if (dv[8:0] !== 9'b100100100) begin errors++; $display("FAIL gap0_done got %b exp 100100100", dv[8:0]); end
    do_stop();
    checks += 1;
    if (busy !== 1'b0 || out !== 1'b0) begin errors++; $display("FAIL gap0_stop busy %b out %b exp 0 0", busy, out); end
  endtask

  task automatic test_stop();
    fire(8'd8, 8'd0, 1'b0);
    observe(3);
    checks += 2;
    if (ov[2:0] !== 3'b111 || dv[2:0] !== 3'b000) begin errors++; $display("FAIL stop_pre out %b done %b exp 111 000", ov[2:0], dv[2:0]); end
    if (out !== 1'b1) begin errors++; $display("FAIL stop_cycle4 out %b exp 1", out); end
    do_stop();
    observe(6);
    checks += 1;
    if (ov[5:0] !== 6'h0 || dv[5:0] !== 6'h0 || bv[5:0] !== 6'h0) begin
      errors++; $display("FAIL stop_post out %h done %h busy %h exp 0 0 0", ov[5:0], dv[5:0], bv[5:0]);
    end
    stop = 1'b1; start = 1'b1; len = 8'd5;
    step();
    stop = 1'b0; start = 1'b0;
    observe(4);
    checks += 1;
    if (ov[3:0] !== 4'h0 || bv[3:0] !== 4'h0) begin errors++; $display("FAIL stop_start_idle out %h busy %h exp 0 0", ov[3:0], bv[3:0]); end
  endtask

  task automatic test_start_busy();
    int highs;
    fire(8'd8, 8'd0, 1'b0);
    observe(1);
    highs = ov[0] + out;
    start = 1'b1; len = 8'd5;
    step();
    start = 1'b0;
    observe(10);
    highs += $countones(ov[9:0]);
    checks += 2;
`ifdef PULSE_TIMER_RETRIG_EN
    if (highs !== 7) begin errors++; $display("FAIL busy_start_highs got %0d exp 7", highs); end
`else
    if (highs !== 8) begin errors++; $display("FAIL busy_start_highs got %0d exp 8", highs); end
`endif
    if ($countones(dv[9:0]) !== 1) begin errors++; $display("FAIL busy_start_dones got %0d exp 1", $countones(dv[9:0])); end
  endtask

  task automatic test_reset_mid();
    fire(8'd8, 8'd0, 1'b0);
    observe(2);
    reset_b = 1'b0;
    #1;
    checks += 3;
    if (out !== 1'b0) begin errors++; $display("FAIL rst_mid_out got %b exp 0", out); end
    if (busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy got %b exp 0", busy); end
    if (done !== 1'b0) begin errors++; $display("FAIL rst_mid_done got %b exp 0", done); end
    step();
    reset_b = 1'b1;
    step();
    fire(8'd2, 8'd0, 1'b0);
    observe(4);
    checks += 2;
    if (ov[3:0] !== 4'b0011) begin errors++; $display("FAIL rst_mid_pulse got %b exp 0011", ov[3:0]); end
    if (dv[3:0] !== 4'b0010) begin errors++; $display("FAIL rst_mid_done2 got %b exp 0010", dv[3:0]); end
  endtask

  task automatic test_back_to_back();
    fire(8'd2, 8'd0, 1'b0);
    observe(2);
    checks += 2;
    if (ov[1:0] !== 2'b11) begin errors++; $display("FAIL b2b_first got %b exp 11", ov[1:0]); end
    if (busy !== 1'b0) begin errors++; $display("FAIL b2b_idle busy %b exp 0", busy); end
    fire(8'd3, 8'd0, 1'b0);
    observe(5);
    checks += 2;
    if (ov[4:0] !== 5'b00111) begin errors++; $display("FAIL b2b_second got %b exp 00111", ov[4:0]); end
    if (dv[4:0] !== 5'b00100) begin errors++; $display("FAIL b2b_done got %b exp 00100", dv[4:0]); end
  endtask

  initial begin
    test_reset();
    test_one_shot();
    test_zero_len();
    test_max_len();
    test_periodic();
    test_stop();
    test_start_busy();
    test_reset_mid();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
